rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised N:1 multiplexer with valid/ready handshakes on every input and on the output.
- Arbitrates among requesting channels, round-robin or fixed-priority, and registers the winner's word plus its channel index.
- Successor to the plain combinational case-mux: adds width, channel count, arbitration mode and back-pressure.
- Sits between several producers and one shared consumer, e.g. a shared bus or a single-port FIFO.

Parameters:
- N_CH, 4, number of input channels; legal range is N_CH >= 2.
- W, 4, data width per channel in bits.
- RR_MODE, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with the lowest index winning.
- Derived, not overridable: CH_W = $clog2(N_CH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N_CH  bit i set = channel i offers a word.
- in_data  input  N_CH*W  flattened channel words; channel i occupies bits [i*W +: W].
- in_ready  output  N_CH  bit i set = channel i's word is accepted this cycle; at most one bit set.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered word.
- out_ch  output  CH_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the output word this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
  - in_ready is forced to all 0 combinationally while rst=1.
- Define load = !out_valid || out_ready, i.e. the output register is empty or is being drained this cycle.
- Grant (combinational):
  - RR_MODE=1: the first set bit of in_valid scanning ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
  - RR_MODE=0: the lowest set bit of in_valid.
- in_ready = onehot(grant) when load and in_valid is non-zero; otherwise all 0.
  - in_ready depends on in_valid and out_ready in the same cycle. This combinational path is intentional.
  - Any in_valid bit may rise or fall at any time. The arbiter never stalls on a channel that drops its request.
- Input transfer on channel i: in_valid[i] && in_ready[i] at the clock edge.
  - Next cycle: out_valid=1, out_data=in_data[i], out_ch=i. Latency is 1 cycle.
- Output transfer: out_valid && out_ready at the clock edge.
  - A new input transfer may occur in the same cycle, giving one word per cycle sustained throughput.
- Load with no input request: out_valid<=0; out_data and out_ch keep their previous values.
- Hold (out_valid && !out_ready): out_valid, out_data and out_ch stay stable and in_ready is all 0. No word is dropped or overwritten.
- Pointer update:
  - On every input transfer in RR_MODE=1: ptr <= (grant==N_CH-1) ? 0 : grant+1. This wrap is correct for non-power-of-two N_CH.
  - The pointer is unchanged otherwise.
  - In RR_MODE=0 the pointer is held at 0 and unused.
- Fairness (RR_MODE=1): with all channels requesting continuously and out_ready=1, grants cycle 0,1,...,N_CH-1,0,... Each channel is granted within N_CH transfers of requesting.
- Single requester: that channel is granted every load cycle, regardless of ptr.
- Reset mid-operation: a word held in the output register is discarded. The pointer returns to 0. The first grant after reset follows ptr=0.
- No internal storage beyond the one output register, the pointer and the control flops. The intended state machine has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY to FULL on an input transfer.
  - FULL stays FULL on hold, or on a drain with a simultaneous input transfer.
  - FULL to EMPTY on a drain with no input request.

Test Plan:
- Reset then idle: with rst=1 for 2 cycles, then in_valid=0 and out_ready=1 -> out_valid=0, out_data=0, out_ch=0 and in_ready=0 every cycle.
- Round-robin rotation: N_CH=4, W=4, RR_MODE=1, in_data words {d,c,b,a} for channels 3..0, in_valid=4'b1111 held and out_ready=1.
  - Required: in_ready walks 0001, 0010, 0100, 1000, 0001.
  - Required: starting 1 cycle later, (out_ch,out_data) = (0,a), (1,b), (2,c), (3,d), (0,a).
- Back-pressure: load channel 2 with word 7, then out_ready=0 for 3 cycles while in_valid=4'b1111.
  - Required: out_valid=1, out_data=7, out_ch=2 stable, and in_ready=0 throughout.
  - Required: after out_ready rises, the next grant is channel 3.
- Skip and wrap: ptr=3 with in_valid=4'b0101 -> grant channel 0, then ptr=1 -> grant channel 2, then ptr=3 -> grant channel 0.
- Fixed priority: RR_MODE=0 with in_valid=4'b1110 held -> channel 1 is granted every cycle. After in_valid[1] falls, channel 2 is granted.
- Reset mid-operation: assert rst with out_valid=1 and ptr=2.
  - Required: next cycle out_valid=0.
  - Required: after release with in_valid=4'b1111, the first grant is channel 0.
- Non-power-of-two: N_CH=3, all channels requesting -> out_ch sequence 0,1,2,0; out_ch never equals 3.

Source files
------------

// File: rtl/rr_arb_mux.sv
// ============================================================================
// Module  : rr_arb_mux
// Brief   : N:1 valid/ready mux, round-robin or fixed-priority grant, with a
//           single registered output stage (word + source channel index).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb_mux #(
   parameter int N_CH    = 4,
   parameter int W       = 4,
   parameter int RR_MODE = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_CH-1:0]           in_valid,
   input  logic [N_CH*W-1:0]         in_data,
   output logic [N_CH-1:0]           in_ready,
   output logic                      out_valid,
   output logic [W-1:0]              out_data,
   output logic [$clog2(N_CH)-1:0]   out_ch,
   input  logic                      out_ready
);

   localparam int                CH_W     = $clog2(N_CH);
   localparam logic [N_CH-1:0]   ONE_HOT0 = {{(N_CH-1){1'b0}}, 1'b1};
   localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(N_CH - 1);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [CH_W-1:0]   ptr;
   logic [CH_W-1:0]   ptr_nxt;

   logic              any_req;
   logic              load;
   logic              xfer;

   logic [N_CH-1:0]   hi_mask;
   logic [N_CH-1:0]   req_hi;
   logic [N_CH-1:0]   fp_oh;
   logic [N_CH-1:0]   rr_oh;
   logic [N_CH-1:0]   gnt_oh;

   logic [N_CH*CH_W-1:0] idx_terms;
   logic [N_CH*W-1:0]    data_terms;
   logic [CH_W-1:0]      gnt_idx;
   logic [W-1:0]         gnt_data;

   assign any_req = |in_valid;
   assign load    = (state == S_EMPTY) || out_ready;
   assign xfer    = load && any_req && !rst;

   // Round-robin: lowest request at or above ptr, else wrap to lowest overall.
   // x & (~x + 1) isolates the lowest set bit.
   assign hi_mask = ~((ONE_HOT0 << ptr) - ONE_HOT0);
   assign req_hi  = in_valid & hi_mask;
   assign fp_oh   = in_valid & (~in_valid + ONE_HOT0);
   assign rr_oh   = (|req_hi) ? (req_hi & (~req_hi + ONE_HOT0)) : fp_oh;
   assign gnt_oh  = (RR_MODE != 0) ? rr_oh : fp_oh;

   for (genvar i = 0; i < N_CH; i++) begin : g_sel
      assign idx_terms[i*CH_W +: CH_W] = gnt_oh[i] ? CH_W'(i) : '0;
      assign data_terms[i*W +: W]      = gnt_oh[i] ? in_data[i*W +: W] : '0;
   end

   // Grant is one-hot, so OR-ing the masked terms acts as the mux.
   always_comb begin
      gnt_idx  = '0;
      gnt_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         gnt_idx  = gnt_idx  | CH_W'(idx_terms  >> (i * CH_W));
         gnt_data = gnt_data | W'(data_terms >> (i * W));
      end
   end

   always_comb begin
      ptr_nxt = ptr;
      if ((RR_MODE != 0) && xfer) begin
         ptr_nxt = (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = xfer ? gnt_oh : '0;
      out_valid = (state == S_FULL);
      case (state)
         S_EMPTY: if (xfer)                    state_nxt = S_FULL;
         S_FULL:  if (out_ready && !any_req)   state_nxt = S_EMPTY;
         default:                              state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         out_data <= '0;
         out_ch   <= '0;
      end else begin
         ptr <= ptr_nxt;
         if (xfer) begin
            out_data <= gnt_data;
            out_ch   <= gnt_idx;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// ============================================================================
// Module  : tb_rr_arb_mux
// Brief   : Directed bench for rr_arb_mux: RR (4ch), fixed priority, 3ch RR.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_arb_mux;

   logic        clk = 1'b0;
   logic        rst;

   logic [3:0]  v4, r4;
   logic [15:0] d4;
   logic        ov4, ordy4;
   logic [3:0]  od4;
   logic [1:0]  och4;

   logic [3:0]  vf, rf;
   logic [15:0] df;
   logic        ovf, ordyf;
   logic [3:0]  odf;
   logic [1:0]  ochf;

   logic [2:0]  v3, r3;
   logic [11:0] d3;
   logic        ov3, ordy3;
   logic [3:0]  od3;
   logic [1:0]  och3;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rr_arb_mux #(.N_CH(4), .W(4), .RR_MODE(1)) u_rr (
      .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(r4),
      .out_valid(ov4), .out_data(od4), .out_ch(och4), .out_ready(ordy4));

   rr_arb_mux #(.N_CH(4), .W(4), .RR_MODE(0)) u_fp (
      .clk(clk), .rst(rst), .in_valid(vf), .in_data(df), .in_ready(rf),
      .out_valid(ovf), .out_data(odf), .out_ch(ochf), .out_ready(ordyf));

   rr_arb_mux #(.N_CH(3), .W(4), .RR_MODE(1)) u_n3 (
      .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_ready(r3),
      .out_valid(ov3), .out_data(od3), .out_ch(och3), .out_ready(ordy3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; v4 = 4'hF; ordy4 = 1'b1;
      #1;
      vectors++;
      if (r4 !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 0000", r4);
      end
      tick(); tick();
      vectors++;
      if ({ov4, och4, od4} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b ch=%0d d=%h want 0/0/0", ov4, och4, od4);
      end
      rst = 1'b0; v4 = 4'h0;
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors++;
         if (r4 !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_in_ready[%0d]: got %b want 0000", k, r4);
         end
         tick();
         vectors++;
         if ({ov4, och4, od4} !== 7'b0) begin
            miscompares++;
            $display("FAIL idle_out[%0d]: got v=%b ch=%0d d=%h want 0/0/0", k, ov4, och4, od4);
         end
      end
   endtask

   task automatic test_rotation();
      logic [3:0] words [4];
      logic [3:0] exp_rdy;
      words = '{4'h5, 4'h6, 4'h9, 4'hC};
      d4 = 16'hC965; v4 = 4'hF; ordy4 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_rdy = 4'b0001 << (k % 4);
         #1;
         vectors++;
         if (r4 !== exp_rdy) begin
            miscompares++;
            $display("FAIL rot_ready[%0d]: got %b want %b", k, r4, exp_rdy);
         end
         tick();
         vectors++;
         if ({ov4, och4, od4} !== {1'b1, 2'(k % 4), words[k % 4]}) begin
            miscompares++;
            $display("FAIL rot_out[%0d]: got v=%b ch=%0d d=%h want 1/%0d/%h",
                     k, ov4, och4, od4, k % 4, words[k % 4]);
         end
      end
   endtask

   task automatic test_back_pressure();
      d4 = 16'hC765; v4 = 4'b0100; ordy4 = 1'b1;
      #1;
      vectors++;
      if (r4 !== 4'b0100) begin
         miscompares++;
         $display("FAIL bp_load_ready: got %b want 0100", r4);
      end
      tick();
      ordy4 = 1'b0; v4 = 4'hF;
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors++;
         if (r4 !== 4'b0000) begin
            miscompares++;
            $display("FAIL bp_hold_ready[%0d]: got %b want 0000", k, r4);
         end
         tick();
         vectors++;
         if ({ov4, och4, od4} !== {1'b1, 2'd2, 4'h7}) begin
            miscompares++;
            $display("FAIL bp_hold_out[%0d]: got v=%b ch=%0d d=%h want 1/2/7", k, ov4, och4, od4);
         end
      end
      ordy4 = 1'b1;
      #1;
      vectors++;
      if (r4 !== 4'b1000) begin
         miscompares++;
         $display("FAIL bp_release_ready: got %b want 1000", r4);
      end
      tick();
      vectors++;
      if ({ov4, och4, od4} !== {1'b1, 2'd3, 4'hC}) begin
         miscompares++;
         $display("FAIL bp_release_out: got v=%b ch=%0d d=%h want 1/3/c", ov4, och4, od4);
      end
   endtask

   task automatic test_skip_wrap();
      logic [1:0] exp_ch [3];
      logic [3:0] exp_d  [3];
      exp_ch = '{2'd0, 2'd2, 2'd0};
      exp_d  = '{4'h5, 4'h7, 4'h5};
      v4 = 4'b0100;
      tick();
      v4 = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors++;
         if (r4 !== (4'b0001 << exp_ch[k])) begin
            miscompares++;
            $display("FAIL skip_ready[%0d]: got %b want ch%0d", k, r4, exp_ch[k]);
         end
         tick();
         vectors++;
         if ({ov4, och4, od4} !== {1'b1, exp_ch[k], exp_d[k]}) begin
            miscompares++;
            $display("FAIL skip_out[%0d]: got v=%b ch=%0d d=%h want 1/%0d/%h",
                     k, ov4, och4, od4, exp_ch[k], exp_d[k]);
         end
      end
   endtask

   task automatic test_single_and_drain();
      v4 = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors++;
         if (r4 !== 4'b1000) begin
            miscompares++;
            $display("FAIL single_ready[%0d]: got %b want 1000", k, r4);
         end
         tick();
      end
      v4 = 4'b0000;
      #1;
      vectors++;
      if (r4 !== 4'b0000) begin
         miscompares++;
         $display("FAIL drain_ready: got %b want 0000", r4);
      end
      tick();
      vectors++;
      if ({ov4, och4, od4} !== {1'b0, 2'd3, 4'hC}) begin
         miscompares++;
         $display("FAIL drain_out: got v=%b ch=%0d d=%h want 0/3/c", ov4, och4, od4);
      end
   endtask

   task automatic test_reset_mid();
      v4 = 4'b0010;
      tick();
      vectors++;
      if ({ov4, och4, od4} !== {1'b1, 2'd1, 4'h6}) begin
         miscompares++;
         $display("FAIL rmid_pre: got v=%b ch=%0d d=%h want 1/1/6", ov4, och4, od4);
      end
      rst = 1'b1; v4 = 4'hF;
      #1;
      vectors++;
      if (r4 !== 4'b0000) begin
         miscompares++;
         $display("FAIL rmid_ready: got %b want 0000", r4);
      end
      tick();
      vectors++;
      if ({ov4, och4, od4} !== 7'b0) begin
         miscompares++;
         $display("FAIL rmid_out: got v=%b ch=%0d d=%h want 0/0/0", ov4, och4, od4);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (r4 !== 4'b0001) begin
         miscompares++;
         $display("FAIL rmid_first_grant: got %b want 0001", r4);
      end
      tick();
      vectors++;
      if ({ov4, och4, od4} !== {1'b1, 2'd0, 4'h5}) begin
         miscompares++;
         $display("FAIL rmid_first_out: got v=%b ch=%0d d=%h want 1/0/5", ov4, och4, od4);
      end
      v4 = 4'b0000;
      tick();
   endtask

   task automatic test_fixed_priority();
      df = 16'hC965; ordyf = 1'b1; vf = 4'b1110;
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors++;
         if (rf !== 4'b0010) begin
            miscompares++;
            $display("FAIL fp_ready[%0d]: got %b want 0010", k, rf);
         end
         tick();
         vectors++;
         if ({ovf, ochf, odf} !== {1'b1, 2'd1, 4'h6}) begin
            miscompares++;
            $display("FAIL fp_out[%0d]: got v=%b ch=%0d d=%h want 1/1/6", k, ovf, ochf, odf);
         end
      end
      vf = 4'b1100;
      #1;
      vectors++;
      if (rf !== 4'b0100) begin
         miscompares++;
         $display("FAIL fp_drop_ready: got %b want 0100", rf);
      end
      tick();
      vectors++;
      if ({ovf, ochf, odf} !== {1'b1, 2'd2, 4'h9}) begin
         miscompares++;
         $display("FAIL fp_drop_out: got v=%b ch=%0d d=%h want 1/2/9", ovf, ochf, odf);
      end
      vf = 4'b0000;
   endtask

   task automatic test_npot();
      logic [3:0] words [3];
      logic [2:0] exp_rdy;
      words = '{4'h5, 4'h6, 4'h9};
      d3 = 12'h965; ordy3 = 1'b1; v3 = 3'b111;
      for (int k = 0; k < 4; k++) begin
         exp_rdy = 3'b001 << (k % 3);
         #1;
         vectors++;
         if (r3 !== exp_rdy) begin
            miscompares++;
            $display("FAIL n3_ready[%0d]: got %b want %b", k, r3, exp_rdy);
         end
         tick();
         vectors++;
         if ({ov3, och3, od3} !== {1'b1, 2'(k % 3), words[k % 3]}) begin
            miscompares++;
            $display("FAIL n3_out[%0d]: got v=%b ch=%0d d=%h want 1/%0d/%h",
                     k, ov3, och3, od3, k % 3, words[k % 3]);
         end
         vectors++;
         if (och3 === 2'd3) begin
            miscompares++;
            $display("FAIL n3_ch_range[%0d]: got ch=%0d want <3", k, och3);
         end
      end
      v3 = 3'b000;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      v4 = '0; d4 = '0; ordy4 = 1'b1;
      vf = '0; df = '0; ordyf = 1'b1;
      v3 = '0; d3 = '0; ordy3 = 1'b1;
      test_reset();
      test_rotation();
      test_back_pressure();
      test_skip_wrap();
      test_single_and_drain();
      test_reset_mid();
      test_fixed_priority();
      test_npot();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
